// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: requester-side and register-side signals of the shared write port
//   req      per-requester write request
//   lock     per-requester hold-ownership request
//   wdata    requester i data at [i*WIDTH +: WIDTH]
//   gnt      one-hot write acknowledge for the current cycle
//   reg_din  data to the shared register din
//   reg_en   enable to the shared register
//   busy     port currently owned
//   owner_id index of the current owner
// modport master: requesters and register side (drives req/lock/wdata)
// modport slave:  the arbiter (drives gnt/reg_din/reg_en/busy/owner_id)
interface reg_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       lock;
    logic [NUM_REQ*WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]       gnt;
    logic [WIDTH-1:0]         reg_din;
    logic                     reg_en;
    logic                     busy;
    logic [IDW-1:0]           owner_id;
    modport master (
        output req, lock, wdata,
        input  gnt, reg_din, reg_en, busy, owner_id
    );
    modport slave (
        input  req, lock, wdata,
        output gnt, reg_din, reg_en, busy, owner_id
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin owner of a shared register write port with lock and hold timeout
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  reg_write_arbiter_if.slave: req/lock/wdata in; gnt/reg_din/reg_en/busy/owner_id out
module reg_write_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    reg_write_arbiter_if.slave bus
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW  = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   owner, owner_nxt;
    logic [IDW-1:0]   ptr, ptr_nxt;
    logic [HW-1:0]    hold_cnt, hold_nxt;
    logic [IDW-1:0]   win;
    logic             found;
    logic [IDW:0]     idx;
    logic             rel;
    logic [WIDTH-1:0] wd [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_wd
        assign wd[i] = bus.wdata[i*WIDTH +: WIDTH];
    end

    // ptr always holds (last owner + 1) mod NUM_REQ, or 0 after reset,
    // so one search serves both the IDLE and the OWN case.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NUM_REQ))
                idx = idx - (IDW+1)'(NUM_REQ);
            if (!found && bus.req[idx[IDW-1:0]]) begin
                found = 1'b1;
                win   = idx[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        bus.gnt     = '0;
        bus.reg_en  = 1'b0;
        bus.reg_din = '0;
        bus.busy    = state == OWN;
        // The hold limit counts cycles already owned, idle holds included.
        rel = !bus.lock[owner] || (hold_cnt == HW'(MAX_HOLD - 1));
        if (state == OWN) begin
            bus.gnt[owner] = bus.req[owner];
            bus.reg_en     = bus.req[owner];
            bus.reg_din    = bus.req[owner] ? wd[owner] : '0;
        end
        if (state == IDLE || rel) begin
            if (found) begin
                state_nxt = OWN;
                owner_nxt = win;
                ptr_nxt   = (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                hold_nxt  = '0;
            end else begin
                state_nxt = IDLE;
            end
        end else begin
            hold_nxt = hold_cnt + 1'b1;
        end
    end

    assign bus.owner_id = owner;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: table-driven, scoreboarded check of reg_write_arbiter
module tb_reg_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   row = -1;

    always #5 clk = ~clk;

    reg_write_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) bus ();

    reg_write_arbiter #(.NUM_REQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] lock;
        logic [3:0] gnt;
        logic       en;
        logic [7:0] din;
        logic       busy;
        logic [1:0] own;
    } vec_t;

    vec_t vt [39];
    vec_t sb [$];

    function automatic vec_t mk(logic r, logic [3:0] rq, logic [3:0] lk, logic [3:0] g,
                                logic e, logic [7:0] d, logic b, logic [1:0] o);
        vec_t v;
        v.rst = r; v.req = rq; v.lock = lk; v.gnt = g;
        v.en = e; v.din = d; v.busy = b; v.own = o;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic chk_all(input vec_t e);
        chk("gnt", int'(bus.gnt), int'(e.gnt));
        chk("reg_en", int'(bus.reg_en), int'(e.en));
        chk("reg_din", int'(bus.reg_din), int'(e.din));
        chk("busy", int'(bus.busy), int'(e.busy));
        chk("owner_id", int'(bus.owner_id), int'(e.own));
        chk("onehot", int'($onehot0(bus.gnt)), 1);
        chk("en_vs_gnt", int'(bus.reg_en), int'(|bus.gnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // wdata: req0=B1 req1=A5 req2=C3 req3=D4
        bus.wdata = 32'hD4C3A5B1;
        bus.req   = '0;
        bus.lock  = '0;
        // single request, then idle
        vt[0]  = mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 0, 0);
        vt[1]  = mk(0, 4'b0010, 4'b0000, 4'b0000, 0, 8'h00, 0, 0);
        vt[2]  = mk(0, 4'b0010, 4'b0000, 4'b0010, 1, 8'hA5, 1, 1);
        vt[3]  = mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 1, 1);
        vt[4]  = mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 0, 1);
        // fairness after reset: 0,1,2,3,0,1
        vt[5]  = mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 0, 0);
        vt[6]  = mk(0, 4'b1111, 4'b0000, 4'b0000, 0, 8'h00, 0, 0);
        vt[7]  = mk(0, 4'b1111, 4'b0000, 4'b0001, 1, 8'hB1, 1, 0);
        vt[8]  = mk(0, 4'b1111, 4'b0000, 4'b0010, 1, 8'hA5, 1, 1);
        vt[9]  = mk(0, 4'b1111, 4'b0000, 4'b0100, 1, 8'hC3, 1, 2);
        vt[10] = mk(0, 4'b1111, 4'b0000, 4'b1000, 1, 8'hD4, 1, 3);
        vt[11] = mk(0, 4'b1111, 4'b0000, 4'b0001, 1, 8'hB1, 1, 0);
        vt[12] = mk(0, 4'b1111, 4'b0000, 4'b0010, 1, 8'hA5, 1, 1);
        vt[13] = mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 1, 2);
        // locked timeout: 4 cycles of owner 2, then 3, then 2
        vt[14] = mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 0, 0);
        vt[15] = mk(0, 4'b1100, 4'b0100, 4'b0000, 0, 8'h00, 0, 0);
        vt[16] = mk(0, 4'b1100, 4'b0100, 4'b0100, 1, 8'hC3, 1, 2);
        vt[17] = mk(0, 4'b1100, 4'b0100, 4'b0100, 1, 8'hC3, 1, 2);
        vt[18] = mk(0, 4'b1100, 4'b0100, 4'b0100, 1, 8'hC3, 1, 2);
        vt[19] = mk(0, 4'b1100, 4'b0100, 4'b0100, 1, 8'hC3, 1, 2);
        vt[20] = mk(0, 4'b1100, 4'b0100, 4'b1000, 1, 8'hD4, 1, 3);
        vt[21] = mk(0, 4'b1100, 4'b0100, 4'b0100, 1, 8'hC3, 1, 2);
        vt[22] = mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 1, 2);
        vt[23] = mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 0, 2);
        // locked owner 1 with a one-cycle request gap
        vt[24] = mk(0, 4'b0010, 4'b0010, 4'b0000, 0, 8'h00, 0, 2);
        vt[25] = mk(0, 4'b0010, 4'b0010, 4'b0010, 1, 8'hA5, 1, 1);
        vt[26] = mk(0, 4'b0000, 4'b0010, 4'b0000, 0, 8'h00, 1, 1);
        vt[27] = mk(0, 4'b0010, 4'b0010, 4'b0010, 1, 8'hA5, 1, 1);
        vt[28] = mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 1, 1);
        // lone requester 3 re-wins every cycle
        vt[29] = mk(0, 4'b1000, 4'b0000, 4'b0000, 0, 8'h00, 0, 1);
        vt[30] = mk(0, 4'b1000, 4'b0000, 4'b1000, 1, 8'hD4, 1, 3);
        vt[31] = mk(0, 4'b1000, 4'b0000, 4'b1000, 1, 8'hD4, 1, 3);
        vt[32] = mk(0, 4'b1000, 4'b0000, 4'b1000, 1, 8'hD4, 1, 3);
        vt[33] = mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 1, 3);
        vt[34] = mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 0, 3);
        // pointer wraps 3 -> 0; non-owner locks are ignored
        vt[35] = mk(0, 4'b0001, 4'b1110, 4'b0000, 0, 8'h00, 0, 3);
        vt[36] = mk(0, 4'b0001, 4'b1110, 4'b0001, 1, 8'hB1, 1, 0);
        vt[37] = mk(0, 4'b0000, 4'b1110, 4'b0000, 0, 8'h00, 1, 0);
        vt[38] = mk(0, 4'b0000, 4'b1110, 4'b0000, 0, 8'h00, 0, 0);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 39; i++) begin
            vec_t e;
            @(posedge clk);
            #1;
            rst      = vt[i].rst;
            bus.req  = vt[i].req;
            bus.lock = vt[i].lock;
            sb.push_back(vt[i]);
            #4;
            e   = sb.pop_front();
            row = i;
            chk_all(e);
        end

        // asynchronous reset while owned: outputs drop before the next edge
        row = 100;
        @(posedge clk);
        #1 bus.req = 4'b0100;
        bus.lock = 4'b0100;
        @(posedge clk);
        #1;
        chk("async_pre_busy", int'(bus.busy), 1);
        chk("async_pre_gnt", int'(bus.gnt), 4'b0100);
        #2 rst = 1'b1;
        #1;
        chk("async_gnt", int'(bus.gnt), 0);
        chk("async_en", int'(bus.reg_en), 0);
        chk("async_din", int'(bus.reg_din), 0);
        chk("async_busy", int'(bus.busy), 0);
        chk("async_owner", int'(bus.owner_id), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.req  = 4'b1111;
        bus.lock = 4'b0000;
        #1;
        chk("post_rst_idle", int'(bus.busy), 0);
        @(posedge clk);
        #1;
        chk("post_rst_gnt", int'(bus.gnt), 4'b0001);
        chk("post_rst_owner", int'(bus.owner_id), 0);
        chk("post_rst_din", int'(bus.reg_din), 8'hB1);
        bus.req = '0;
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
